// File: rtl/branch_issue_control.sv
// Decode-stage control generator and issue sequencer feeding the ID/EX control register.
// Holds off decode through the branch shadow and around flag hazards, and flushes on a taken branch.
module branch_issue_control #(
    parameter int BRANCH_SHADOW = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrD,
    input  logic        StallD,
    input  logic        PCSrcE,
    output logic [2:0]  OpcodeE,
    output logic        VE,
    output logic        PCSE,
    output logic        RegWE,
    output logic        MemWE,
    output logic [1:0]  FlagWE,
    output logic        BusyD
);

    typedef struct packed {
        logic [2:0] opcode;
        logic       v;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic [1:0] flagw;
    } ctrl_t;

    localparam logic [0:0] S_RUN     = 1'b0;
    localparam logic [0:0] S_BR_WAIT = 1'b1;

    localparam logic [2:0] COND_AL  = 3'b110;
    localparam logic [2:0] CNT_LOAD = 3'(BRANCH_SHADOW - 1);

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam ctrl_t BUBBLE = '{opcode: COND_AL, v: 1'b0, pcs: 1'b0,
                                 regw: 1'b0, memw: 1'b0, flagw: 2'b00};

    logic [0:0] r_state;
    logic [2:0] r_cnt;
    ctrl_t      r_ctrl;

    logic [2:0] w_cond;
    logic [1:0] w_op;
    logic       w_s;
    logic       w_l;
    ctrl_t      w_dec;
    logic       w_flag_hazard;
    logic       w_unused_bits;

    assign w_cond        = InstrD[31:29];
    assign w_op          = InstrD[27:26];
    assign w_s           = InstrD[25];
    assign w_l           = InstrD[20];
    assign w_unused_bits = ^{InstrD[24:21], InstrD[19:0]};

    // NOTE: every field gets a default before the case so no path leaves a latch behind.
    always_comb begin
        w_dec        = BUBBLE;
        w_dec.opcode = w_cond;
        w_dec.v      = InstrD[28];
        case (w_op)
            OP_DP: begin
                w_dec.regw  = 1'b1;
                w_dec.flagw = w_s ? 2'b11 : 2'b00;
            end
            OP_MEM: begin
                w_dec.regw = w_l;
                w_dec.memw = ~w_l;
            end
            OP_BR:   w_dec.pcs = 1'b1;
            default: ;
        endcase
    end

    // A conditional instruction right behind a flag setter must wait one cycle for the flags.
    assign w_flag_hazard = (r_state == S_RUN) && (w_cond != COND_AL) && (r_ctrl.flagw != 2'b00);

    assign BusyD = ~PCSrcE & ((r_state == S_BR_WAIT) | w_flag_hazard | StallD);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctrl  <= BUBBLE;
            r_state <= S_RUN;
            r_cnt   <= 3'd0;
        end else if (PCSrcE) begin
            r_ctrl  <= BUBBLE;
            r_state <= S_RUN;
            r_cnt   <= 3'd0;
        end else if (!StallD) begin
            if (r_state == S_BR_WAIT) begin
                r_ctrl <= BUBBLE;
                if (r_cnt == 3'd0) begin
                    r_state <= S_RUN;
                end else begin
                    r_cnt <= r_cnt - 3'd1;
                end
            end else if (w_flag_hazard) begin
                r_ctrl <= BUBBLE;
            end else begin
                r_ctrl <= w_dec;
                if (w_op == OP_BR) begin
                    r_state <= S_BR_WAIT;
                    r_cnt   <= CNT_LOAD;
                end
            end
        end
    end

    assign OpcodeE = r_ctrl.opcode;
    assign VE      = r_ctrl.v;
    assign PCSE    = r_ctrl.pcs;
    assign RegWE   = r_ctrl.regw;
    assign MemWE   = r_ctrl.memw;
    assign FlagWE  = r_ctrl.flagw;

endmodule

// File: tb/tb_branch_issue_control.sv
// Directed bench for branch_issue_control: a stimulus process pushes expectations per cycle,
// a monitor on the falling edge pops and compares BusyD and the E-stage controls.
module tb_branch_issue_control;

    logic        clk;
    logic        rst;
    logic [31:0] InstrD;
    logic        StallD;
    logic        PCSrcE;
    logic [2:0]  OpcodeE;
    logic        VE;
    logic        PCSE;
    logic        RegWE;
    logic        MemWE;
    logic [1:0]  FlagWE;
    logic        BusyD;

    branch_issue_control #(.BRANCH_SHADOW(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .InstrD  (InstrD),
        .StallD  (StallD),
        .PCSrcE  (PCSrcE),
        .OpcodeE (OpcodeE),
        .VE      (VE),
        .PCSE    (PCSE),
        .RegWE   (RegWE),
        .MemWE   (MemWE),
        .FlagWE  (FlagWE),
        .BusyD   (BusyD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [31:0] instr;
        logic        stall;
        logic        pcsrc;
        logic        busy;
        logic [8:0]  e;
    } vec_t;

    typedef struct {
        int         idx;
        logic       busy;
        logic [8:0] e;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [31:0] mk(input logic [2:0] cond, input logic v,
                                       input logic [1:0] op, input logic s, input logic l);
        logic [31:0] r;
        r        = 32'h0000_0000;
        r[31:29] = cond;
        r[28]    = v;
        r[27:26] = op;
        r[25]    = s;
        r[20]    = l;
        return r;
    endfunction

    // {OpcodeE, VE, PCSE, RegWE, MemWE, FlagWE}
    function automatic logic [8:0] ev(input logic [2:0] op, input logic v, input logic pcs,
                                      input logic regw, input logic memw, input logic [1:0] flagw);
        return {op, v, pcs, regw, memw, flagw};
    endfunction

    task automatic add(input logic rst_n, input logic [31:0] instr, input logic stall,
                       input logic pcsrc, input logic busy, input logic [8:0] e);
        vec_t t;
        t.rst_n = rst_n;
        t.instr = instr;
        t.stall = stall;
        t.pcsrc = pcsrc;
        t.busy  = busy;
        t.e     = e;
        vecs.push_back(t);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t x;
            logic [8:0] act;
            x   = sb_q.pop_front();
            act = {OpcodeE, VE, PCSE, RegWE, MemWE, FlagWE};
            n_checks++;
            if (BusyD !== x.busy || act !== x.e) begin
                n_errors++;
                $display("FAIL row%0d: got busy=%0b E=%b, expected busy=%0b E=%b",
                         x.idx, BusyD, act, x.busy, x.e);
            end
        end
    end

    initial begin
        logic [31:0] add_i, cmp_i, addeq_i, ldr_i, str_i, b_i, addv_i, nopc_i;
        logic [8:0]  e_bub, e_add, e_cmp, e_ldr, e_str, e_b, e_addeq, e_addv, e_nopc;

        add_i   = mk(3'b110, 1'b0, 2'b00, 1'b0, 1'b0);
        cmp_i   = mk(3'b110, 1'b0, 2'b00, 1'b1, 1'b0);
        addeq_i = mk(3'b011, 1'b0, 2'b00, 1'b0, 1'b0);
        ldr_i   = mk(3'b110, 1'b0, 2'b01, 1'b0, 1'b1);
        str_i   = mk(3'b110, 1'b0, 2'b01, 1'b0, 1'b0);
        b_i     = mk(3'b110, 1'b0, 2'b10, 1'b0, 1'b0);
        addv_i  = mk(3'b110, 1'b1, 2'b00, 1'b0, 1'b0);
        nopc_i  = mk(3'b101, 1'b0, 2'b11, 1'b0, 1'b0);

        e_bub   = ev(3'b110, 0, 0, 0, 0, 2'b00);
        e_add   = ev(3'b110, 0, 0, 1, 0, 2'b00);
        e_cmp   = ev(3'b110, 0, 0, 1, 0, 2'b11);
        e_ldr   = ev(3'b110, 0, 0, 1, 0, 2'b00);
        e_str   = ev(3'b110, 0, 0, 0, 1, 2'b00);
        e_b     = ev(3'b110, 0, 1, 0, 0, 2'b00);
        e_addeq = ev(3'b011, 0, 0, 1, 0, 2'b00);
        e_addv  = ev(3'b110, 1, 0, 1, 0, 2'b00);
        e_nopc  = ev(3'b101, 0, 0, 0, 0, 2'b00);

        // Each row: inputs held this cycle, expected BusyD this cycle, E outputs from the previous edge.
        add(0, add_i,   0, 0, 0, e_bub);   // 0  in reset
        add(1, add_i,   0, 0, 0, e_bub);   // 1  release, ADD issues at next edge
        add(1, ldr_i,   0, 0, 0, e_add);   // 2
        add(1, str_i,   0, 0, 0, e_ldr);   // 3
        add(1, b_i,     0, 0, 0, e_str);   // 4  branch issues
        add(1, add_i,   0, 0, 1, e_b);     // 5  shadow 1
        add(1, add_i,   0, 0, 1, e_bub);   // 6  shadow 2
        add(1, add_i,   0, 0, 0, e_bub);   // 7  ADD issues on 4th edge
        add(1, cmp_i,   0, 0, 0, e_add);   // 8
        add(1, addeq_i, 0, 0, 1, e_cmp);   // 9  flag hazard
        add(1, addeq_i, 0, 0, 0, e_bub);   // 10
        add(1, cmp_i,   0, 0, 0, e_addeq); // 11
        add(1, cmp_i,   0, 0, 0, e_cmp);   // 12 back-to-back setters, no hazard
        add(1, addv_i,  0, 0, 0, e_cmp);   // 13
        add(1, b_i,     0, 0, 0, e_addv);  // 14
        add(1, add_i,   1, 1, 0, e_b);     // 15 flush with stall in first BR_WAIT cycle
        add(1, add_i,   0, 0, 0, e_bub);   // 16
        add(1, str_i,   0, 0, 0, e_add);   // 17
        add(1, add_i,   1, 0, 1, e_str);   // 18 stall hold x3
        add(1, add_i,   1, 0, 1, e_str);   // 19
        add(1, add_i,   1, 0, 1, e_str);   // 20
        add(1, add_i,   0, 0, 0, e_str);   // 21
        add(1, b_i,     0, 0, 0, e_add);   // 22
        add(1, add_i,   0, 0, 1, e_b);     // 23
        add(1, add_i,   1, 0, 1, e_bub);   // 24 stall inside BR_WAIT holds cnt
        add(1, add_i,   0, 0, 1, e_bub);   // 25
        add(1, add_i,   0, 0, 0, e_bub);   // 26
        add(1, b_i,     0, 0, 0, e_add);   // 27
        add(1, add_i,   0, 1, 0, e_b);     // 28 flush during BR_WAIT
        add(1, add_i,   0, 1, 0, e_bub);   // 29 PCSrcE still high: another bubble
        add(1, add_i,   0, 0, 0, e_bub);   // 30
        add(1, b_i,     0, 0, 0, e_add);   // 31
        add(0, add_i,   0, 0, 0, e_bub);   // 32 async reset mid-BR_WAIT
        add(1, add_i,   0, 0, 0, e_bub);   // 33
        add(1, nopc_i,  0, 0, 0, e_add);   // 34
        add(1, add_i,   0, 0, 0, e_nopc);  // 35

        rst    = 1'b0;
        InstrD = add_i;
        StallD = 1'b0;
        PCSrcE = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            exp_t x;
            @(posedge clk);
            #1;
            rst    = vecs[i].rst_n;
            InstrD = vecs[i].instr;
            StallD = vecs[i].stall;
            PCSrcE = vecs[i].pcsrc;
            x.idx  = i;
            x.busy = vecs[i].busy;
            x.e    = vecs[i].e;
            sb_q.push_back(x);
        end

        for (int w = 0; w < 5 && sb_q.size() > 0; w++) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
